// File: rtl/instr_encoder_loader_if.sv
// Load-port bundle of the instruction encoder/loader: decoded instruction
// fields in over a valid/ready handshake, instruction-RAM write bus and
// loader status out.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [2:0]        rm;
  logic [1:0]        sh;
  logic [7:0]        im8;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_dout;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  // Program source / host side
  modport master (
    output clear, in_valid, opcode, op, rn, rd, rm, sh, im8,
    input  in_ready, mem_write, mem_addr, mem_dout, count, full, err
  );

  // Loader side
  modport slave (
    input  clear, in_valid, opcode, op, rn, rd, rm, sh, im8,
    output in_ready, mem_write, mem_addr, mem_dout, count, full, err
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs decoded instruction fields into 16-bit
// words and writes them to consecutive instruction-memory addresses so a
// program can be loaded before the CPU is released. Illegal opcode/op
// combinations raise a sticky error flag and are dropped.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  instr_encoder_loader_if.slave    bus
);

  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_dout_q, mem_dout_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic              in_ready;
  logic              handshake;
  logic [16:0]       enc;

  // Returns {legal, word}; fields a sub-operation does not use are forced to 0.
  function automatic logic [16:0] encode(
    input logic [2:0] opcode,
    input logic [1:0] op,
    input logic [2:0] rn,
    input logic [2:0] rd,
    input logic [2:0] rm,
    input logic [1:0] sh,
    input logic [7:0] im8
  );
    logic [16:0] r;
    r = '0;
    case ({opcode, op})
      5'b110_10:           r = {1'b1, opcode, op, rn, im8};
      5'b110_00:           r = {1'b1, opcode, op, 3'b000, rd, sh, rm};
      5'b101_00, 5'b101_10: r = {1'b1, opcode, op, rn, rd, sh, rm};
      5'b101_01:           r = {1'b1, opcode, op, rn, 3'b000, sh, rm};
      5'b101_11:           r = {1'b1, opcode, op, 3'b000, rd, sh, rm};
      default:             r = '0;
    endcase
    return r;
  endfunction

  // Ready is combinational so it falls as soon as reset asserts or clear rises.
  assign in_ready  = reset_n & (state_q == IDLE) & ~full_q & ~bus.clear;
  assign handshake = bus.in_valid & in_ready;
  assign enc       = encode(bus.opcode, bus.op, bus.rn, bus.rd, bus.rm,
                            bus.sh, bus.im8);

  // Next-state logic for the IDLE/WRITE controller and its registered outputs.
  always_comb begin
    state_d     = state_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_dout_d  = mem_dout_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          mem_addr_d = BASE_A;
          count_d    = '0;
          full_d     = 1'b0;
          err_d      = 1'b0;
        end else if (handshake) begin
          if (enc[16]) begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_dout_d  = enc[15:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // The in-flight write always completes; clear only rewinds afterwards.
        state_d = IDLE;
        if (bus.clear) begin
          mem_addr_d = BASE_A;
          count_d    = '0;
          full_d     = 1'b0;
          err_d      = 1'b0;
        end else if (count_q != DEPTH_C) begin
          count_d = count_q + CNT_ONE;
          if (count_q == DEPTH_C - CNT_ONE) begin
            full_d = 1'b1;
          end else begin
            mem_addr_d = mem_addr_q + ADR_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset is asynchronous so a write in flight is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_write_q <= 1'b0;
      mem_addr_q  <= BASE_A;
      mem_dout_q  <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_dout_q  <= mem_dout_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.err       = err_q;

endmodule
